discrete_value_sampler: RTL
===========================

Name: discrete_value_sampler

Overview:
- Consumer end of the discrete-range interface.
- Accepts one selected range per variable: index, start, end and an equal flag, as produced by the discrete range randomizer.
- Draws a uniformly distributed signed integer in [start, end] using an internal LFSR with bounded rejection sampling.
- Returns the value tagged with the same variable index; sits between the range randomizer and the variable register file of the MCMC solver.

Parameters:
- MAX_BIT_WIDTH_OF_INTEGER_VARIABLE, 8, signed width W of start/end/value; legal range 2..31.
- MAX_BIT_WIDTH_OF_VARIABLES_INDEX, 4, width of the variable index tag.
- MAX_TRIES, 4, rejection attempts before forced fallback; legal range 1..15.

Ports:
- in_clock  input  1  clock, rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_enable  input  1  global advance; when low, FSM, LFSR and outputs hold.
- in_seed  input  32  LFSR seed, sampled only while in_reset is high.
- in_valid  input  1  range request valid.
- in_variable_index  input  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  tag of the requesting variable.
- in_start  input  W  signed range start.
- in_end  input  W  signed range end.
- in_equal  input  1  range is a single value; output in_start.
- out_ready  output  1  high in IDLE while in_enable is high.
- out_valid  output  1  one-cycle result strobe.
- out_value  output  W  signed sampled value.
- out_variable_index  output  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  tag echoed from the request.
- out_error  output  1  strobe with out_valid when in_start > in_end.

Behaviour:
- Reset: while in_reset is high, state=IDLE and out_valid=out_error=0. out_value=0, out_variable_index=0, tries=0. LFSR loads in_seed; a zero seed loads 32'h1. Reset overrides everything, including mid-SAMPLE; the pending request is dropped and no out_valid is produced.
- LFSR: 32-bit Galois, polynomial 0x80200003. It advances one step per cycle only in SAMPLE with in_enable high.
- Accept: a request is taken on a cycle where in_valid && out_ready. Start, index, span and mask are latched on that cycle.
- span = in_end - in_start, computed in W+1 bits.
- mask = smallest 2^k-1 that is >= span, computed by OR-smearing span.
- FSM has three states: IDLE, SAMPLE, DONE.
  - IDLE → DONE with out_value=in_start and out_error=0 when in_equal=1 or span==0.
  - IDLE → DONE with out_value=in_start and out_error=1 when signed in_start > in_end.
  - IDLE → SAMPLE otherwise, with tries=0.
  - SAMPLE: candidate = lfsr[W:0] & mask.
    - If candidate <= span: value = start + candidate, go to DONE.
    - Else if tries == MAX_TRIES-1: value = start + (candidate >> 1), go to DONE. This value is guaranteed within range.
    - Else: tries++ and stay in SAMPLE.
  - DONE: out_valid=1 for exactly one cycle (with out_error if flagged), then IDLE. out_value and out_variable_index hold until the next result.
- Latency from accept edge T:
  - equal, zero span or error: out_valid during cycle T+1.
  - first-try hit: out_valid during T+2.
  - worst case: out_valid during T+1+MAX_TRIES.
- Throughput: out_ready is low in SAMPLE and DONE; a new accept is possible in the cycle after DONE.
- in_enable low in any state freezes state, tries and LFSR; a DONE strobe is extended until the enabled cycle. out_ready=0 while in_enable is low.
- Arithmetic: start + offset is computed in W+1 bits and truncated to W. The in-range guarantee makes truncation lossless.
- No output is ever outside [start, end] for a valid request.

Test Plan:
- Reset with in_seed=0, then request start=-3, end=4 → LFSR equals 32'h1 after reset; out_valid arrives within 2..6 cycles; value is in [-3,4].
- in_equal=1, start=5, end=7, index=2 → out_valid at T+1, out_value=5, out_variable_index=2, no LFSR step.
- start=end=-2, in_equal=0 → out_valid at T+1, out_value=-2, out_error=0.
- start=3, end=-1 → out_valid at T+1, out_value=3, out_error=1.
- 2000 back-to-back requests with start=-3, end=4, seed 32'hACE1 → all 8 values appear; each count within 250±60; none out of range.
- Mid-SAMPLE in_enable low for 5 cycles, then in_reset pulsed mid-SAMPLE → no state or LFSR change while disabled; no out_valid after reset; next request is serviced normally.

Source files
------------

// File: rtl/discrete_value_sampler.sv
// discrete_value_sampler: draws a uniform signed integer in [start, end] for one
// variable at a time, using a 32-bit Galois LFSR with bounded rejection sampling.
// The result is tagged with the requesting variable's index.
module discrete_value_sampler #(
    parameter int unsigned MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
    parameter int unsigned MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 4,
    parameter int unsigned MAX_TRIES                         = 4
) (
    input  logic                                        in_clock,
    input  logic                                        in_reset,
    input  logic                                        in_enable,
    input  logic [31:0]                                 in_seed,
    input  logic                                        in_valid,
    input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] in_variable_index,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_start,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_end,
    input  logic                                        in_equal,
    output logic                                        out_ready,
    output logic                                        out_valid,
    output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_value,
    output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] out_variable_index,
    output logic                                        out_error
);

    localparam int unsigned W  = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
    localparam int unsigned IW = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
    localparam int unsigned SW = W + 1;
    localparam int unsigned TW = 4;
    localparam logic [31:0]   POLY     = 32'h8020_0003;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tries_q, tries_d;
    logic [31:0]     lfsr;
    logic [W-1:0]    start_q;
    logic [SW-1:0]   span_q;
    logic [SW-1:0]   mask_q;
    logic [IW-1:0]   index_q;
    logic            err_q, err_d;
    logic [W-1:0]    value_d;
    logic [IW-1:0]   out_index_d;
    logic            load_req;

    logic [SW-1:0]   span_c;
    logic [SW-1:0]   mask_c;
    logic            start_gt_end_c;
    logic [SW-1:0]   candidate_c;
    logic [SW-1:0]   hit_sum_c;
    logic [SW-1:0]   fallback_sum_c;

    // Smallest all-ones value covering v, built by OR-smearing every lower bit.
    function automatic logic [SW-1:0] smear(input logic [SW-1:0] v);
        logic [SW-1:0] m;
        m = v;
        for (int i = 1; i < int'(SW); i++) begin
            m = m | (v >> i);
        end
        return m;
    endfunction

    // Range arithmetic on the incoming request and on the latched candidate.
    always_comb begin
        span_c         = {in_end[W-1], in_end} - {in_start[W-1], in_start};
        mask_c         = smear(span_c);
        start_gt_end_c = $signed(in_start) > $signed(in_end);
        candidate_c    = lfsr[SW-1:0] & mask_q;
        hit_sum_c      = {start_q[W-1], start_q} + candidate_c;
        fallback_sum_c = {start_q[W-1], start_q} + (candidate_c >> 1);
    end

    assign out_ready = (state_q == IDLE) && in_enable;
    assign out_valid = (state_q == DONE);
    assign out_error = (state_q == DONE) && err_q;

    // Next-state, retry counter and result selection.
    always_comb begin
        state_d     = state_q;
        tries_d     = tries_q;
        err_d       = err_q;
        value_d     = out_value;
        out_index_d = out_variable_index;
        load_req    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && out_ready) begin
                    load_req = 1'b1;
                    if (start_gt_end_c) begin
                        value_d     = in_start;
                        out_index_d = in_variable_index;
                        err_d       = 1'b1;
                        state_d     = DONE;
                    end else if (in_equal || (span_c == '0)) begin
                        value_d     = in_start;
                        out_index_d = in_variable_index;
                        err_d       = 1'b0;
                        state_d     = DONE;
                    end else begin
                        tries_d = '0;
                        err_d   = 1'b0;
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (in_enable) begin
                    if (candidate_c <= span_q) begin
                        value_d     = hit_sum_c[W-1:0];
                        out_index_d = index_q;
                        state_d     = DONE;
                    end else if (tries_q == LAST_TRY) begin
                        // Halving a rejected candidate always lands inside the span.
                        value_d     = fallback_sum_c[W-1:0];
                        out_index_d = index_q;
                        state_d     = DONE;
                    end else begin
                        tries_d = tries_q + TW'(1);
                    end
                end
            end
            DONE: begin
                if (in_enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request latches, result registers and LFSR.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q            <= IDLE;
            tries_q            <= '0;
            err_q              <= 1'b0;
            out_value          <= '0;
            out_variable_index <= '0;
            start_q            <= '0;
            span_q             <= '0;
            mask_q             <= '0;
            index_q            <= '0;
            lfsr               <= (in_seed == 32'h0) ? 32'h1 : in_seed;
        end else begin
            state_q            <= state_d;
            tries_q            <= tries_d;
            err_q              <= err_d;
            out_value          <= value_d;
            out_variable_index <= out_index_d;
            if (load_req) begin
                start_q <= in_start;
                span_q  <= span_c;
                mask_q  <= mask_c;
                index_q <= in_variable_index;
            end
            if ((state_q == SAMPLE) && in_enable) begin
                lfsr <= {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & POLY);
            end
        end
    end

endmodule
